visor_debug_port: RTL

VISOR_DEBUG_PORT -- requirements
Module: visor_debug_port

---
 rtl/visor_pkg.sv | 25 ++
 rtl/visor_bp_unit.sv | 41 ++++
 rtl/visor_debug_port.sv | 110 +++++++++++
 3 files changed

// File: rtl/visor_pkg.sv
// rtl/visor_pkg.sv - register map, control bit positions and constants for the visor debug port
package visor_pkg;

  localparam logic [3:0] REG_BP0       = 4'd0;
  localparam logic [3:0] REG_BP1       = 4'd1;
  localparam logic [3:0] REG_BP2       = 4'd2;
  localparam logic [3:0] REG_BP3       = 4'd3;
  localparam logic [3:0] REG_BUS_CTRL  = 4'd4;
  localparam logic [3:0] REG_TG_FORCE  = 4'd5;
  localparam logic [3:0] REG_CODE_IN   = 4'd6;
  localparam logic [3:0] REG_BP_STATUS = 4'd7;
  localparam logic [3:0] REG_EXR       = 4'd8;
  localparam logic [3:0] REG_TO_VISOR  = 4'd9;

  localparam int BUS_TG_RESET = 1;
  localparam int BUS_DIVERT   = 2;

  localparam int FORCE_HOLD     = 0;
  localparam int FORCE_LOAD_EXR = 1;
  localparam int FORCE_EXEC     = 2;

  localparam logic [15:0] BP_DISABLED    = 16'hFFFF;
  localparam logic [15:0] BUS_CTRL_RESET = 16'h0002;

endpackage

// File: rtl/visor_bp_unit.sv
// rtl/visor_bp_unit.sv - one breakpoint comparator with pass-once skip and sticky status
module visor_bp_unit
  import visor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [15:0] wr_data,
  input  logic        fetch,
  input  logic [15:0] code_addr,
  input  logic        suppress,
  output logic [15:0] addr,
  output logic        status,
  output logic        match
);

  logic skip;
  logic addr_eq;

  assign addr_eq = (code_addr == addr);
  assign match   = fetch & ~suppress & addr_eq & (addr != BP_DISABLED) & ~skip;

  // A write re-arms the comparator so execution can step past the breakpoint once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr   <= BP_DISABLED;
      skip   <= 1'b0;
      status <= 1'b0;
    end else if (wr) begin
      addr   <= wr_data;
      skip   <= 1'b1;
      status <= 1'b0;
    end else begin
      if (match)
        status <= 1'b1;
      if (fetch && !suppress && !addr_eq)
        skip <= 1'b0;
    end
  end

endmodule

// File: rtl/visor_debug_port.sv
// rtl/visor_debug_port.sv - visor register file, breakpoints, force pulses and code-bus divert
module visor_debug_port
  import visor_pkg::*;
#(
  parameter int NUM_BP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vis_wr_en,
  input  logic [3:0]  vis_wr_addr,
  input  logic [15:0] vis_wr_data,
  input  logic [3:0]  vis_rd_addr,
  output logic [15:0] vis_rd_data,
  input  logic [15:0] tg_code_addr,
  input  logic        tg_fetch,
  input  logic        tg_exr_load,
  input  logic [15:0] tg_rom_data,
  input  logic [15:0] tg_to_visor_data,
  input  logic        tg_to_visor_wr,
  output logic [15:0] tg_code_data,
  output logic        tg_reset,
  output logic        tg_debug_hold,
  output logic        tg_debug_force_load_exr,
  output logic        tg_debug_force_exec
);

  logic [15:0]       bus_ctrl;
  logic [15:0]       tg_force;
  logic [15:0]       tg_code_in;
  logic [15:0]       exr_shadow;
  logic [15:0]       tg_to_visor;
  logic [15:0]       bp_addr [NUM_BP];
  logic [NUM_BP-1:0] bp_status;
  logic [NUM_BP-1:0] bp_match;
  logic              divert;
  logic              force_wr;

  assign tg_reset = bus_ctrl[BUS_TG_RESET];
  assign divert   = bus_ctrl[BUS_DIVERT];
  assign force_wr = vis_wr_en && (vis_wr_addr == REG_TG_FORCE);

  genvar i;
  generate
    for (i = 0; i < NUM_BP; i++) begin : g_bp
      visor_bp_unit u_bp (
        .clk       (clk),
        .reset     (reset),
        .wr        (vis_wr_en && (vis_wr_addr == REG_BP0 + 4'(i))),
        .wr_data   (vis_wr_data),
        .fetch     (tg_fetch),
        .code_addr (tg_code_addr),
        .suppress  (tg_reset),
        .addr      (bp_addr[i]),
        .status    (bp_status[i]),
        .match     (bp_match[i])
      );
    end
  endgenerate

  // The live match term lets the target stall on the very fetch that hits.
  assign tg_debug_hold = tg_force[FORCE_HOLD] | (|bp_status) | (|bp_match);
  assign tg_code_data  = divert ? tg_code_in : tg_rom_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ctrl                <= BUS_CTRL_RESET;
      tg_force                <= 16'h0000;
      tg_code_in              <= 16'h0000;
      exr_shadow              <= 16'h0000;
      tg_to_visor             <= 16'h0000;
      tg_debug_force_load_exr <= 1'b0;
      tg_debug_force_exec     <= 1'b0;
    end else begin
      tg_debug_force_load_exr <= 1'b0;
      tg_debug_force_exec     <= 1'b0;
      if (vis_wr_en && vis_wr_addr == REG_BUS_CTRL)
        bus_ctrl <= vis_wr_data;
      if (vis_wr_en && vis_wr_addr == REG_CODE_IN)
        tg_code_in <= vis_wr_data;
      if (force_wr) begin
        tg_force                <= vis_wr_data;
        tg_debug_force_load_exr <= vis_wr_data[FORCE_LOAD_EXR] & ~tg_force[FORCE_LOAD_EXR];
        tg_debug_force_exec     <= vis_wr_data[FORCE_EXEC] & ~tg_force[FORCE_EXEC];
      end
      // Forced code is not the real program word, so keep the shadow untouched while diverted.
      if (tg_exr_load && !divert)
        exr_shadow <= tg_rom_data;
      if (tg_to_visor_wr)
        tg_to_visor <= tg_to_visor_data;
    end
  end

  always_comb begin
    vis_rd_data = 16'h0000;
    case (vis_rd_addr)
      REG_BP0:       vis_rd_data = bp_addr[0];
      REG_BP1:       vis_rd_data = bp_addr[1];
      REG_BP2:       vis_rd_data = bp_addr[2];
      REG_BP3:       vis_rd_data = bp_addr[3];
      REG_BUS_CTRL:  vis_rd_data = bus_ctrl;
      REG_TG_FORCE:  vis_rd_data = tg_force;
      REG_CODE_IN:   vis_rd_data = tg_code_in;
      REG_BP_STATUS: vis_rd_data = 16'(bp_status);
      REG_EXR:       vis_rd_data = exr_shadow;
      REG_TO_VISOR:  vis_rd_data = tg_to_visor;
      default:       vis_rd_data = 16'h0000;
    endcase
  end

endmodule
